// File: rtl/ic_fill_ctrl.sv
// I-cache line fill controller.
// Takes a line miss from the fetch i-cache, issues one burst read to the memory
// arbiter, assembles the narrow read beats into a full line and returns it with a
// one-cycle ack. An abort after the grant drains the rest of the burst so that
// stale beats never land in a later fill.
module ic_fill_ctrl #(
    parameter int unsigned BEAT_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // i-cache miss side
    input  logic              ic_miss,
    input  logic [31:0]       ic_miss_addr,
    input  logic              ic_fill_abort,
    // memory arbiter side
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rd_valid,
    input  logic [BEAT_W-1:0] mem_rd_data,
    // fill return
    output logic [LINE_W-1:0] ic_fill_data,
    output logic              ic_miss_ack,
    output logic [31:0]       ic_miss_ack_addr,
    output logic              fill_busy
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StBeat  = 3'd2;
    localparam logic [2:0] StAck   = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       line_addr_q, line_addr_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              beat_last;
    logic [CNT_W-1:0]  cnt_next;

    // Low address bits select a byte within the line and play no part in the fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ic_miss_addr[4:0];

    // A valid beat at the top count closes the burst; the counter wraps back to zero there.
    assign beat_last = mem_rd_valid && (cnt_q == LAST_BEAT);
    assign cnt_next  = beat_last ? '0 : cnt_q + CNT_W'(1);

    // Next-state logic for the fill FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        line_addr_d = line_addr_q;
        fill_d      = fill_q;

        case (state_q)
            StIdle: begin
                if (ic_miss && !ic_fill_abort) begin
                    line_addr_d = {ic_miss_addr[31:5], 5'b0};
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    state_d     = StReq;
                end
            end

            StReq: begin
                if (mem_gnt) begin
                    // Once granted the burst belongs to us, so an abort must drain it.
                    mem_req_d = 1'b0;
                    state_d   = ic_fill_abort ? StDrain : StBeat;
                end else if (ic_fill_abort) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            StBeat: begin
                if (ic_fill_abort) begin
                    // The beat in this cycle is counted but not stored.
                    if (mem_rd_valid) begin
                        cnt_d = cnt_next;
                    end
                    // Aborting on the final beat leaves nothing to drain.
                    state_d = beat_last ? StIdle : StDrain;
                end else if (mem_rd_valid) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            fill_d[b*BEAT_W +: BEAT_W] = mem_rd_data;
                        end
                    end
                    cnt_d = cnt_next;
                    if (beat_last) begin
                        state_d = StAck;
                    end
                end
            end

            StAck: begin
                // Abort is ignored here: the line is already complete.
                state_d = StIdle;
            end

            StDrain: begin
                if (mem_rd_valid) begin
                    cnt_d = cnt_next;
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        ack_d  = (state_d == StAck);
        busy_d = (state_d != StIdle);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            line_addr_q <= '0;
            fill_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            line_addr_q <= line_addr_d;
            fill_q      <= fill_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_addr         = line_addr_q;
    assign ic_fill_data     = fill_q;
    assign ic_miss_ack      = ack_q;
    assign ic_miss_ack_addr = line_addr_q;
    assign fill_busy        = busy_q;

    // Structural invariants of the protocol.
    ack_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        ic_miss_ack |=> !ic_miss_ack);
    req_only_in_req: assert property (@(posedge clk) disable iff (!rst_n)
        mem_req |-> (state_q == StReq));
    ack_implies_busy_before: assert property (@(posedge clk) disable iff (!rst_n)
        ic_miss_ack |-> fill_busy);

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed bench for ic_fill_ctrl: nominal fill, wait states, aborts, held miss,
// stray beats and asynchronous reset mid-fill.
module tb_ic_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ic_miss = 1'b0;
    logic [31:0]  ic_miss_addr = '0;
    logic         ic_fill_abort = 1'b0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rd_valid = 1'b0;
    logic [31:0]  mem_rd_data = '0;
    logic [255:0] ic_fill_data;
    logic         ic_miss_ack;
    logic [31:0]  ic_miss_ack_addr;
    logic         fill_busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    ic_fill_ctrl #(
        .BEAT_W(32),
        .LINE_W(256)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ic_miss          (ic_miss),
        .ic_miss_addr     (ic_miss_addr),
        .ic_fill_abort    (ic_fill_abort),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .ic_fill_data     (ic_fill_data),
        .ic_miss_ack      (ic_miss_ack),
        .ic_miss_ack_addr (ic_miss_ack_addr),
        .fill_busy        (fill_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected line for beats base, base+1, ... in ascending order.
    function automatic logic [255:0] line_of(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int b = 0; b < 8; b++) begin
            l[b*32 +: 32] = base + 32'(b);
        end
        return l;
    endfunction

    // Raise a miss, let IDLE sample it and check the request went out.
    task automatic start_req(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input bit hold, input string tag, output int c0);
        ic_miss      = 1'b1;
        ic_miss_addr = addr;
        tick();
        c0 = cyc;
        if (!hold) ic_miss = 1'b0;
        check({tag, "_req"}, 256'(mem_req), 256'(1));
        check({tag, "_addr"}, 256'(mem_addr), 256'(exp_addr));
        check({tag, "_busy"}, 256'(fill_busy), 256'(1));
    endtask

    // From REQ: grant after gnt_dly cycles, deliver 8 beats with gaps, check the ack.
    task automatic finish_fill(input logic [31:0] exp_addr, input int gnt_dly, input int gap,
                               input logic [31:0] base, input bit stray, input bit chk_lat,
                               input int c0, input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < gnt_dly; i++) begin
            mem_rd_valid = stray;
            mem_rd_data  = 32'h0BAD_0000 + 32'(i);
            tick();
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) ok = 1'b0;
        end
        mem_rd_valid = 1'b0;
        if (gnt_dly > 0) check({tag, "_req_stable"}, 256'(ok), 256'(1));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, "_req_drop"}, 256'(mem_req), 256'(0));
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = base + 32'(b);
            tick();
            mem_rd_valid = 1'b0;
            if (mem_req !== 1'b0) ok = 1'b0;
            if (b < 7) begin
                if (ic_miss_ack !== 1'b0) ok = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (ic_miss_ack !== 1'b0 || mem_req !== 1'b0) ok = 1'b0;
                end
            end
        end
        check({tag, "_no_early_ack_or_req"}, 256'(ok), 256'(1));
        check({tag, "_ack"}, 256'(ic_miss_ack), 256'(1));
        check({tag, "_ack_addr"}, 256'(ic_miss_ack_addr), 256'(exp_addr));
        check({tag, "_data"}, ic_fill_data, line_of(base));
        if (chk_lat) check({tag, "_latency"}, 256'(cyc - c0 + 1), 256'(10));
        tick();
        check({tag, "_ack_pulse"}, 256'(ic_miss_ack), 256'(0));
        check({tag, "_idle"}, 256'(fill_busy), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  c0;
        bit  ok;

        // Reset values
        #1;
        check("rst_req", 256'(mem_req), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_data", ic_fill_data, 256'(0));
        check("rst_ack", 256'(ic_miss_ack), 256'(0));
        check("rst_ack_addr", 256'(ic_miss_ack_addr), 256'(0));
        check("rst_busy", 256'(fill_busy), 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: nominal fill, no wait states
        start_req(32'h0000_1A3F, 32'h0000_1A20, 1'b0, "t1", c0);
        finish_fill(32'h0000_1A20, 0, 0, 32'h0, 1'b0, 1'b1, c0, "t1");
        check("t1_literal", ic_fill_data,
              256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        check("t1_data_hold", ic_fill_data, line_of(32'h0));

        // 2: delayed grant with stray beats in REQ, gaps between beats
        start_req(32'h0000_BEEF, 32'h0000_BEE0, 1'b0, "t2", c0);
        finish_fill(32'h0000_BEE0, 5, 2, 32'h1000_0000, 1'b1, 1'b0, c0, "t2");

        // 3: abort in REQ before grant
        start_req(32'h0000_0180, 32'h0000_0180, 1'b0, "t3a", c0);
        tick();
        check("t3_req_held", 256'(mem_req), 256'(1));
        ic_fill_abort = 1'b1;
        tick();
        ic_fill_abort = 1'b0;
        check("t3_req_dropped", 256'(mem_req), 256'(0));
        check("t3_idle", 256'(fill_busy), 256'(0));
        check("t3_no_ack", 256'(ic_miss_ack), 256'(0));
        tick();
        check("t3_no_ack_later", 256'(ic_miss_ack), 256'(0));
        start_req(32'h0000_0200, 32'h0000_0200, 1'b0, "t3b", c0);
        finish_fill(32'h0000_0200, 0, 0, 32'h0000_0200, 1'b0, 1'b1, c0, "t3b");

        // 4: abort after beat 3, drain beats 4..7, miss during drain held off
        start_req(32'h0000_5000, 32'h0000_5000, 1'b0, "t4a", c0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h50 + 32'(b);
            tick();
        end
        mem_rd_valid  = 1'b0;
        ic_fill_abort = 1'b1;
        tick();
        ic_fill_abort = 1'b0;
        check("t4_drain_busy", 256'(fill_busy), 256'(1));
        check("t4_drain_no_ack", 256'(ic_miss_ack), 256'(0));
        ic_miss      = 1'b1;
        ic_miss_addr = 32'h0000_6004;
        ok = 1'b1;
        for (int b = 4; b < 8; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h50 + 32'(b);
            tick();
            if (ic_miss_ack !== 1'b0 || mem_req !== 1'b0) ok = 1'b0;
            if (b < 7 && fill_busy !== 1'b1) ok = 1'b0;
        end
        mem_rd_valid = 1'b0;
        check("t4_drain_quiet", 256'(ok), 256'(1));
        check("t4_idle_after_drain", 256'(fill_busy), 256'(0));
        tick();
        c0 = cyc;
        ic_miss = 1'b0;
        check("t4_new_req", 256'(mem_req), 256'(1));
        check("t4_new_addr", 256'(mem_addr), 256'(32'h0000_6000));
        finish_fill(32'h0000_6000, 0, 0, 32'h0000_0600, 1'b0, 1'b1, c0, "t4b");

        // 5: miss held through a fill, back-to-back fill, then stray beats in IDLE
        start_req(32'h0000_3000, 32'h0000_3000, 1'b1, "t5a", c0);
        finish_fill(32'h0000_3000, 1, 0, 32'h3000_0000, 1'b0, 1'b0, c0, "t5a");
        start_req(32'h0000_4010, 32'h0000_4000, 1'b0, "t5b", c0);
        finish_fill(32'h0000_4000, 0, 1, 32'h4000_0000, 1'b0, 1'b0, c0, "t5b");
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEAD_BEEF;
            tick();
            if (fill_busy !== 1'b0 || mem_req !== 1'b0 || ic_miss_ack !== 1'b0) ok = 1'b0;
        end
        mem_rd_valid = 1'b0;
        check("t5_stray_quiet", 256'(ok), 256'(1));
        check("t5_stray_data", ic_fill_data, line_of(32'h4000_0000));

        // 6: asynchronous reset in the middle of a burst
        start_req(32'h0000_7000, 32'h0000_7000, 1'b0, "t6a", c0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h70 + 32'(b);
            tick();
        end
        mem_rd_data = 32'h73;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 256'(mem_req), 256'(0));
        check("t6_rst_addr", 256'(mem_addr), 256'(0));
        check("t6_rst_data", ic_fill_data, 256'(0));
        check("t6_rst_ack_addr", 256'(ic_miss_ack_addr), 256'(0));
        check("t6_rst_busy", 256'(fill_busy), 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int b = 4; b < 8; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h70 + 32'(b);
            tick();
            if (fill_busy !== 1'b0 || ic_miss_ack !== 1'b0) ok = 1'b0;
        end
        mem_rd_valid = 1'b0;
        check("t6_leftover_quiet", 256'(ok), 256'(1));
        check("t6_leftover_data", ic_fill_data, 256'(0));
        start_req(32'h0000_801F, 32'h0000_8000, 1'b0, "t6b", c0);
        finish_fill(32'h0000_8000, 0, 0, 32'h0000_0080, 1'b0, 1'b1, c0, "t6b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
